uio_bus_arbiter: RTL and testbench

//   Round-robin arbiter sharing the 8-bit bidirectional uio pad bus among NREQ internal requesters.

---
 rtl/uio_bus_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter
// Round-robin owner of the shared 8-bit uio pad bus. One requester at a time
// gets the bus (OWN). Between owners the pads are tri-stated for TURNAROUND
// cycles (TURN). A tenure ends on done, when the owner drops req, or by
// preemption once it has held the bus MAX_HOLD cycles while others wait.
// Every output is taken straight from a flop.

module uio_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     wr,
    input  logic [8*NREQ-1:0]   wdata,
    input  logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     gnt,
    output logic [7:0]          rdata,
    output logic                rvalid,
    output logic                busy,
    input  logic [7:0]          uio_in,
    output logic [7:0]          uio_out,
    output logic [7:0]          uio_oe
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD);
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    // Round-robin scan starting just after the previous owner, so the
    // previous owner itself is considered last.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0] sel;
        logic          found;
        int            idx;
        sel   = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && r[OW'(idx)]) begin
                sel   = OW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [TW-1:0]   turn_cnt_r, turn_cnt_nxt_s;
    logic [HW-1:0]   hold_r, hold_nxt_s;
    logic [OW-1:0]   last_owner_r, last_owner_nxt_s;
    logic [NREQ-1:0] gnt_r, gnt_nxt_s;
    logic [7:0]      uio_oe_r, uio_oe_nxt_s;
    logic [7:0]      uio_out_r, uio_out_nxt_s;
    logic [7:0]      rdata_r, rdata_nxt_s;
    logic            rvalid_r, rvalid_nxt_s;
    logic            busy_r, busy_nxt_s;

    logic [OW-1:0]   pick_s;
    logic [NREQ-1:0] owner_mask_s;
    logic            own_req_s;
    logic            own_wr_s;
    logic            own_done_s;
    logic [7:0]      own_wdata_s;
    logic            others_req_s;
    logic            preempt_s;
    logic            release_s;

    // Owner-side views of the request bundle and release decision.
    always_comb begin
        pick_s       = rr_pick(req, last_owner_r);
        owner_mask_s = {{(NREQ-1){1'b0}}, 1'b1} << last_owner_r;
        own_req_s    = req[last_owner_r];
        own_wr_s     = wr[last_owner_r];
        own_done_s   = done[last_owner_r];
        own_wdata_s  = wdata[{last_owner_r, 3'b000} +: 8];
        others_req_s = |(req & ~owner_mask_s);
        preempt_s    = (hold_r == HW'(MAX_HOLD - 1)) && others_req_s;
        release_s    = own_done_s || !own_req_s || preempt_s;
    end

    // Next-state and next-output logic for the IDLE/TURN/OWN controller.
    always_comb begin
        state_nxt_s      = state_r;
        turn_cnt_nxt_s   = turn_cnt_r;
        hold_nxt_s       = hold_r;
        last_owner_nxt_s = last_owner_r;
        gnt_nxt_s        = gnt_r;
        uio_oe_nxt_s     = uio_oe_r;
        uio_out_nxt_s    = uio_out_r;
        rdata_nxt_s      = rdata_r;
        rvalid_nxt_s     = rvalid_r;

        case (state_r)
            IDLE: begin
                gnt_nxt_s    = {NREQ{1'b0}};
                uio_oe_nxt_s = 8'h00;
                rvalid_nxt_s = 1'b0;
                if (|req) begin
                    state_nxt_s    = TURN;
                    turn_cnt_nxt_s = {TW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TURN: begin
                gnt_nxt_s    = {NREQ{1'b0}};
                uio_oe_nxt_s = 8'h00;
                rvalid_nxt_s = 1'b0;
                if (turn_cnt_r == TW'(TURNAROUND - 1)) begin
                    if (|req) begin
                        state_nxt_s      = OWN;
                        gnt_nxt_s        = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
                        last_owner_nxt_s = pick_s;
                        hold_nxt_s       = {HW{1'b0}};
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    turn_cnt_nxt_s = turn_cnt_r + TW'(1);
                end
            end
            OWN: begin
                if (release_s) begin
                    // done and preemption together still mean one release
                    state_nxt_s    = TURN;
                    turn_cnt_nxt_s = {TW{1'b0}};
                    gnt_nxt_s      = {NREQ{1'b0}};
                    uio_oe_nxt_s   = 8'h00;
                    rvalid_nxt_s   = 1'b0;
                end else begin
                    if (hold_r != HW'(MAX_HOLD - 1)) begin
                        hold_nxt_s = hold_r + HW'(1);
                    end else begin
                        hold_nxt_s = hold_r;
                    end
                    if (own_wr_s) begin
                        uio_oe_nxt_s  = 8'hFF;
                        uio_out_nxt_s = own_wdata_s;
                        rvalid_nxt_s  = 1'b0;
                    end else begin
                        uio_oe_nxt_s = 8'h00;
                        rdata_nxt_s  = uio_in;
                        rvalid_nxt_s = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                gnt_nxt_s    = {NREQ{1'b0}};
                uio_oe_nxt_s = 8'h00;
                rvalid_nxt_s = 1'b0;
            end
        endcase

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State register; reset parks the controller in IDLE with owner NREQ-1
    // so the first scan starts at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            turn_cnt_r   <= {TW{1'b0}};
            hold_r       <= {HW{1'b0}};
            last_owner_r <= OW'(NREQ - 1);
        end else begin
            state_r      <= state_nxt_s;
            turn_cnt_r   <= turn_cnt_nxt_s;
            hold_r       <= hold_nxt_s;
            last_owner_r <= last_owner_nxt_s;
        end
    end

    // Output registers; reset tri-states the pads immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r     <= {NREQ{1'b0}};
            uio_oe_r  <= 8'h00;
            uio_out_r <= 8'h00;
            rdata_r   <= 8'h00;
            rvalid_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            gnt_r     <= gnt_nxt_s;
            uio_oe_r  <= uio_oe_nxt_s;
            uio_out_r <= uio_out_nxt_s;
            rdata_r   <= rdata_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign gnt     = gnt_r;
    assign uio_oe  = uio_oe_r;
    assign uio_out = uio_out_r;
    assign rdata   = rdata_r;
    assign rvalid  = rvalid_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter (NREQ=4, MAX_HOLD=16, TURNAROUND=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] wdata;
    logic [3:0]  done;
    logic [3:0]  gnt;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        busy;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int unsigned total = 0;
    int unsigned bad   = 0;

    uio_bus_arbiter #(
        .NREQ       (4),
        .MAX_HOLD   (16),
        .TURNAROUND (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .wr      (wr),
        .wdata   (wdata),
        .done    (done),
        .gnt     (gnt),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    int          order [5]     = '{0, 1, 2, 3, 0};
    logic [7:0]  bytes_tbl [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    initial begin
        rst_n  = 1'b0;
        req    = 4'hF;
        wr     = 4'h0;
        wdata  = 32'h0;
        done   = 4'h0;
        uio_in = 8'h00;
        #1;

        // 1. reset holds everything quiet even with all requests up
        for (int i = 0; i < 3; i++) begin
            chk("rst_gnt", gnt, 4'h0);
            chk("rst_oe", uio_oe, 8'h00);
            chk("rst_out", uio_out, 8'h00);
            chk("rst_busy", busy, 1'b0);
            chk("rst_rvalid", rvalid, 1'b0);
            chk("rst_rdata", rdata, 8'h00);
            step();
        end
        req   = 4'h0;
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 1'b0);

        // 2. write by requester 2
        req   = 4'b0100;
        wr    = 4'b0100;
        wdata = 32'h00A5_0000;
        step();
        chk("t2_turn_gnt", gnt, 4'h0);
        chk("t2_turn_busy", busy, 1'b1);
        step();
        chk("t2_gnt", gnt, 4'b0100);
        chk("t2_oe_first", uio_oe, 8'h00);
        step();
        chk("t2_oe", uio_oe, 8'hFF);
        chk("t2_out", uio_out, 8'hA5);
        chk("t2_rvalid", rvalid, 1'b0);
        done = 4'b0100;
        step();
        chk("t2_rel_gnt", gnt, 4'h0);
        chk("t2_rel_oe", uio_oe, 8'h00);
        done = 4'h0;
        req  = 4'h0;
        wr   = 4'h0;
        step();
        chk("t2_idle_busy", busy, 1'b0);
        chk("t2_out_hold", uio_out, 8'hA5);

        // 3. read by requester 1
        req    = 4'b0010;
        uio_in = 8'h3C;
        step();
        step();
        chk("t3_gnt", gnt, 4'b0010);
        chk("t3_rvalid_first", rvalid, 1'b0);
        step();
        chk("t3_rdata", rdata, 8'h3C);
        chk("t3_rvalid", rvalid, 1'b1);
        chk("t3_oe", uio_oe, 8'h00);
        req = 4'h0;
        step();
        chk("t3_drop_rvalid", rvalid, 1'b0);
        chk("t3_drop_gnt", gnt, 4'h0);
        step();
        chk("t3_idle_busy", busy, 1'b0);

        // 4. round robin with all requesting, done after 3 OWN cycles
        do_reset();
        req   = 4'hF;
        wr    = 4'hF;
        wdata = 32'hD3C2_B1A0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t4_gnt", gnt, 32'(4'b0001 << order[k]));
            chk("t4_oe_first", uio_oe, 8'h00);
            step();
            chk("t4_oe", uio_oe, 8'hFF);
            chk("t4_out", uio_out, bytes_tbl[order[k]]);
            step();
            done = 4'b0001 << order[k];
            step();
            chk("t4_gap_gnt", gnt, 4'h0);
            chk("t4_gap_oe", uio_oe, 8'h00);
            chk("t4_gap_busy", busy, 1'b1);
            done = 4'h0;
            step();
        end
        req = 4'h0;

        // 5. preemption after 16 OWN cycles
        do_reset();
        req   = 4'b0001;
        wr    = 4'b1001;
        wdata = 32'h5AC2_B1A0;
        step();
        step();
        for (int c = 1; c <= 16; c++) begin
            if (c == 5) begin
                req = 4'b1001;
            end else begin
                req = req;
            end
            chk("t5_hold_gnt", gnt, 4'b0001);
            step();
        end
        chk("t5_pre_gnt", gnt, 4'h0);
        chk("t5_pre_oe", uio_oe, 8'h00);
        step();
        chk("t5_next_gnt", gnt, 4'b1000);
        step();

        // 6. async reset mid-write
        chk("t6_oe_drive", uio_oe, 8'hFF);
        chk("t6_out_drive", uio_out, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_oe", uio_oe, 8'h00);
        chk("t6_async_gnt", gnt, 4'h0);
        chk("t6_async_busy", busy, 1'b0);
        step();
        req   = 4'b1000;
        wr    = 4'h0;
        rst_n = 1'b1;
        step();
        step();
        chk("t6_first_gnt3", gnt, 4'b1000);
        req = 4'b1001;
        do_reset();
        step();
        step();
        chk("t6_first_gnt0", gnt, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
